// File: rtl/expr_gen_pkg.sv
// Shared definitions for the arithmetic expression character generator:
// FSM state encoding, ASCII constants and the default operand capacity.
package expr_gen_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      EMIT_D = 2'd1,
      EMIT_O = 2'd2,
      DONE   = 2'd3
   } state_t;

   localparam logic [7:0] ASCII_ZERO = 8'd48;
   localparam logic [7:0] ASCII_PLUS = 8'd43;
   localparam logic [7:0] ASCII_STAR = 8'd42;

   localparam int MAX_OPND_DEF = 8;

endpackage

// File: rtl/expr_gen_chk.sv
// Combinational legality check of an expression request: operand count in
// range and every used operand a decimal digit.
module expr_gen_chk
   import expr_gen_pkg::*;
#(
   parameter int MAX_OPND = MAX_OPND_DEF
) (
   input  logic [3:0]            num_opnd,
   input  logic [4*MAX_OPND-1:0] opnd,
   output logic                  illegal
);

   localparam logic [3:0] MAX_N = 4'(MAX_OPND);

   // Digits beyond the requested count are don't-care and must not flag.
   always_comb begin
      illegal = (num_opnd == 4'd0) || (num_opnd > MAX_N);
      for (int k = 0; k < MAX_OPND; k++) begin
         if ((4'(k) < num_opnd) && (opnd[4*k +: 4] > 4'd9)) begin
            illegal = 1'b1;
         end
      end
   end

endmodule

// File: rtl/expr_gen.sv
// Emits "d op d op ... d" as an ASCII character stream with valid/ready
// handshake. Every output is registered from the next-state decode.
module expr_gen
   import expr_gen_pkg::*;
#(
   parameter int MAX_OPND = MAX_OPND_DEF
) (
   input  logic                  clk,
   input  logic                  clr_n,
   input  logic                  start,
   input  logic [3:0]            num_opnd,
   input  logic [4*MAX_OPND-1:0] opnd,
   input  logic [MAX_OPND-2:0]   op_sel,
   input  logic                  out_ready,
   output logic [7:0]            out,
   output logic                  out_valid,
   output logic                  busy,
   output logic                  done,
   output logic                  err
);

   state_t                state, state_nxt;
   logic [3:0]            idx, idx_nxt;
   logic [3:0]            n_lat, n_nxt;
   logic [4*MAX_OPND-1:0] opnd_lat, opnd_nxt;
   logic [MAX_OPND-2:0]   ops_lat, ops_nxt;
   logic                  err_nxt;
   logic                  accept;
   logic                  illegal;
   logic [3:0]            digit;
   logic                  op_bit;
   logic [7:0]            char_nxt;

   expr_gen_chk #(.MAX_OPND(MAX_OPND)) u_chk (
      .num_opnd (num_opnd),
      .opnd     (opnd),
      .illegal  (illegal)
   );

   // out_valid is a register, so the handshake never combines out_ready
   // straight into an output.
   always_comb begin
      state_nxt = state;
      idx_nxt   = idx;
      n_nxt     = n_lat;
      opnd_nxt  = opnd_lat;
      ops_nxt   = ops_lat;
      err_nxt   = 1'b0;
      accept    = out_valid && out_ready;
      case (state)
         IDLE: begin
            if (start) begin
               if (illegal) begin
                  err_nxt = 1'b1;
               end else begin
                  state_nxt = EMIT_D;
                  idx_nxt   = 4'd0;
                  n_nxt     = num_opnd;
                  opnd_nxt  = opnd;
                  ops_nxt   = op_sel;
               end
            end
         end
         EMIT_D: begin
            if (accept) begin
               state_nxt = (idx == n_lat - 4'd1) ? DONE : EMIT_O;
            end
         end
         EMIT_O: begin
            if (accept) begin
               idx_nxt   = idx + 4'd1;
               state_nxt = EMIT_D;
            end
         end
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Character for the cycle after the edge, taken from next-state data so a
   // stalled character is simply recomputed unchanged.
   always_comb begin
      digit  = 4'd0;
      op_bit = 1'b0;
      for (int k = 0; k < MAX_OPND; k++) begin
         if (idx_nxt == 4'(k)) digit = opnd_nxt[4*k +: 4];
      end
      for (int k = 0; k < MAX_OPND - 1; k++) begin
         if (idx_nxt == 4'(k)) op_bit = ops_nxt[k];
      end
      case (state_nxt)
         EMIT_D:  char_nxt = ASCII_ZERO + {4'd0, digit};
         EMIT_O:  char_nxt = op_bit ? ASCII_STAR : ASCII_PLUS;
         default: char_nxt = 8'd0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!clr_n) begin
         state     <= IDLE;
         idx       <= 4'd0;
         n_lat     <= 4'd0;
         opnd_lat  <= '0;
         ops_lat   <= '0;
         out       <= 8'd0;
         out_valid <= 1'b0;
         busy      <= 1'b0;
         done      <= 1'b0;
         err       <= 1'b0;
      end else begin
         state     <= state_nxt;
         idx       <= idx_nxt;
         n_lat     <= n_nxt;
         opnd_lat  <= opnd_nxt;
         ops_lat   <= ops_nxt;
         out       <= char_nxt;
         out_valid <= (state_nxt == EMIT_D) || (state_nxt == EMIT_O);
         busy      <= (state_nxt == EMIT_D) || (state_nxt == EMIT_O);
         done      <= (state_nxt == DONE);
         err       <= err_nxt;
      end
   end

endmodule

// File: tb/tb_expr_gen.sv
// Directed self-checking bench for expr_gen: normal streams, back-pressure,
// illegal requests, mid-expression reset and the single-operand case.
module tb_expr_gen;

   localparam int MAXN = 8;

   logic              clk = 1'b0;
   logic              clr_n;
   logic              start;
   logic [3:0]        num_opnd;
   logic [4*MAXN-1:0] opnd;
   logic [MAXN-2:0]   op_sel;
   logic              out_ready;
   logic [7:0]        out;
   logic              out_valid;
   logic              busy;
   logic              done;
   logic              err;

   int testsRun    = 0;
   int testsFailed = 0;

   expr_gen #(.MAX_OPND(MAXN)) dut (
      .clk       (clk),
      .clr_n     (clr_n),
      .start     (start),
      .num_opnd  (num_opnd),
      .opnd      (opnd),
      .op_sel    (op_sel),
      .out_ready (out_ready),
      .out       (out),
      .out_valid (out_valid),
      .busy      (busy),
      .done      (done),
      .err       (err)
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
      testsRun++;
      if (actual !== expected) begin
         testsFailed++;
         $display("[TB] FAIL %s: got %0d, expected %0d", tag, actual, expected);
      end
   endtask

   task automatic nextCycle();
      @(posedge clk);
      #1;
   endtask

   // Expected character at stream position p: even = digit, odd = operator.
   function automatic logic [7:0] expChar(input logic [4*MAXN-1:0] dig, input logic [MAXN-2:0] ops, input int p);
      logic [3:0] d;
      if (p % 2 == 0) begin
         d = dig[4*(p/2) +: 4];
         return 8'd48 + {4'd0, d};
      end
      return ops[p/2] ? 8'd42 : 8'd43;
   endfunction

   task automatic applyStimulus(input int n, input logic [4*MAXN-1:0] dig, input logic [MAXN-2:0] ops);
      start    = 1'b1;
      num_opnd = 4'(n);
      opnd     = dig;
      op_sel   = ops;
      nextCycle();
      start    = 1'b0;
      num_opnd = 4'd0;
      opnd     = '1;
      op_sel   = '0;
   endtask

   // Runs a whole expression, optionally stalling on one character and
   // pulsing start while stalled; checks every character, done and idle.
   task automatic runExpr(input string name, input int n, input logic [4*MAXN-1:0] dig,
                          input logic [MAXN-2:0] ops, input int stallAt, input int stallCycles,
                          input bit startInStall);
      logic [7:0] exp;
      applyStimulus(n, dig, ops);
      for (int p = 0; p < 2*n - 1; p++) begin
         exp = expChar(dig, ops, p);
         checkOutput($sformatf("%s_char%0d", name, p), {24'd0, out}, {24'd0, exp});
         checkOutput($sformatf("%s_valid%0d", name, p), {31'd0, out_valid}, 32'd1);
         checkOutput($sformatf("%s_busy%0d", name, p), {31'd0, busy}, 32'd1);
         if (p == stallAt) begin
            out_ready = 1'b0;
            if (startInStall) begin
               start    = 1'b1;
               num_opnd = 4'd2;
               opnd     = 32'h0000_0099;
            end
            for (int s = 0; s < stallCycles; s++) begin
               nextCycle();
               checkOutput($sformatf("%s_hold%0d_%0d", name, p, s), {24'd0, out}, {24'd0, exp});
               checkOutput($sformatf("%s_holdv%0d_%0d", name, p, s), {31'd0, out_valid}, 32'd1);
               checkOutput($sformatf("%s_holdd%0d_%0d", name, p, s), {31'd0, done}, 32'd0);
            end
            start     = 1'b0;
            out_ready = 1'b1;
         end
         nextCycle();
      end
      checkOutput({name, "_done"}, {31'd0, done}, 32'd1);
      checkOutput({name, "_done_valid"}, {31'd0, out_valid}, 32'd0);
      checkOutput({name, "_done_out"}, {24'd0, out}, 32'd0);
      checkOutput({name, "_done_busy"}, {31'd0, busy}, 32'd0);
      nextCycle();
      checkOutput({name, "_done_once"}, {31'd0, done}, 32'd0);
      checkOutput({name, "_idle_valid"}, {31'd0, out_valid}, 32'd0);
      nextCycle();
      checkOutput({name, "_idle_valid2"}, {31'd0, out_valid}, 32'd0);
   endtask

   initial begin
      clr_n     = 1'b0;
      start     = 1'b0;
      num_opnd  = 4'd0;
      opnd      = '0;
      op_sel    = '0;
      out_ready = 1'b1;
      nextCycle();
      nextCycle();
      checkOutput("rst_out", {24'd0, out}, 32'd0);
      checkOutput("rst_valid", {31'd0, out_valid}, 32'd0);
      checkOutput("rst_busy", {31'd0, busy}, 32'd0);
      checkOutput("rst_done", {31'd0, done}, 32'd0);
      checkOutput("rst_err", {31'd0, err}, 32'd0);
      clr_n = 1'b1;
      nextCycle();

      // 1+2*3 : 49,43,50,42,51 back to back
      applyStimulus(3, 32'h0000_0321, 7'b0000010);
      checkOutput("abc_c0", {24'd0, out}, 32'd49);
      nextCycle();
      checkOutput("abc_c1", {24'd0, out}, 32'd43);
      nextCycle();
      checkOutput("abc_c2", {24'd0, out}, 32'd50);
      nextCycle();
      checkOutput("abc_c3", {24'd0, out}, 32'd42);
      nextCycle();
      checkOutput("abc_c4", {24'd0, out}, 32'd51);
      nextCycle();
      checkOutput("abc_done", {31'd0, done}, 32'd1);
      nextCycle();
      checkOutput("abc_done_once", {31'd0, done}, 32'd0);

      runExpr("stall", 3, 32'h0000_0321, 7'b0000010, 1, 3, 1'b0);

      // Illegal digit in operand 0
      applyStimulus(2, 32'h0000_005A, 7'b0000000);
      checkOutput("ill_err", {31'd0, err}, 32'd1);
      checkOutput("ill_valid", {31'd0, out_valid}, 32'd0);
      checkOutput("ill_busy", {31'd0, busy}, 32'd0);
      nextCycle();
      checkOutput("ill_err_pulse", {31'd0, err}, 32'd0);
      checkOutput("ill_valid2", {31'd0, out_valid}, 32'd0);
      applyStimulus(0, 32'h0000_0001, 7'b0000000);
      checkOutput("ill_n0_err", {31'd0, err}, 32'd1);
      nextCycle();
      applyStimulus(9, 32'h1111_1111, 7'b0000000);
      checkOutput("ill_n9_err", {31'd0, err}, 32'd1);
      nextCycle();
      // Bad digit above N is ignored
      runExpr("ignhi", 2, 32'hFFFF_FF45, 7'b0000001, -1, 0, 1'b0);

      // Reset after the second character
      applyStimulus(3, 32'h0000_0654, 7'b0000011);
      checkOutput("rmid_c0", {24'd0, out}, 32'd52);
      nextCycle();
      checkOutput("rmid_c1", {24'd0, out}, 32'd42);
      nextCycle();
      clr_n = 1'b0;
      nextCycle();
      clr_n = 1'b1;
      checkOutput("rmid_valid", {31'd0, out_valid}, 32'd0);
      checkOutput("rmid_busy", {31'd0, busy}, 32'd0);
      checkOutput("rmid_out", {24'd0, out}, 32'd0);
      checkOutput("rmid_done", {31'd0, done}, 32'd0);
      for (int c = 0; c < 3; c++) begin
         nextCycle();
         checkOutput($sformatf("rmid_noresume%0d", c), {31'd0, out_valid}, 32'd0);
         checkOutput($sformatf("rmid_nodone%0d", c), {31'd0, done}, 32'd0);
      end
      runExpr("rrestart", 3, 32'h0000_0654, 7'b0000011, -1, 0, 1'b0);

      // Reset and start at the same edge: reset wins
      clr_n = 1'b0;
      applyStimulus(2, 32'h0000_0012, 7'b0000000);
      clr_n = 1'b1;
      checkOutput("rst_start_valid", {31'd0, out_valid}, 32'd0);
      checkOutput("rst_start_busy", {31'd0, busy}, 32'd0);
      nextCycle();
      checkOutput("rst_start_valid2", {31'd0, out_valid}, 32'd0);

      runExpr("n1", 1, 32'h0000_0007, 7'b0000000, 0, 2, 1'b1);
      runExpr("full", MAXN, 32'h9876_5432, 7'b1111111, -1, 0, 1'b0);

      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule

// File: doc/expr_gen.md
EXPR_GEN -- requirements
Module: expr_gen

Interface
REQ-001 Parameter: MAX_OPND, 8, maximum operand count per expression (range 2..15).
REQ-002 Port: clk  input  1  rising-edge clock.
REQ-003 Port: clr_n  input  1  reset, synchronous and active-low.
REQ-004 Port: start  input  1  request to emit one expression; sampled only in IDLE.
REQ-005 Port: num_opnd  input  4  operand count N, legal range 1..MAX_OPND.
REQ-006 Port: opnd  input  4*MAX_OPND  operand digits; operand i is opnd[4i+3:4i].
REQ-007 Port: op_sel  input  MAX_OPND-1  operator between operand i and i+1: 0 gives '+' (43), 1 gives '*' (42).
REQ-008 Port: out_ready  input  1  downstream accepts the current character.
REQ-009 Port: out  output  8  ASCII character stream that feeds the expression recognizer.
REQ-010 Port: out_valid  output  1  out holds a valid character.
REQ-011 Port: busy  output  1  high in EMIT_D and EMIT_O.
REQ-012 Port: done  output  1  one-cycle pulse after the final character is accepted.
REQ-013 Port: err  output  1  one-cycle pulse when start is rejected.

Function
REQ-014 FSM states SHALL be IDLE, EMIT_D, EMIT_O and DONE, registered and one-hot or binary.
REQ-015 In IDLE, start=1 with legal arguments SHALL latch num_opnd, opnd and op_sel, clear index i to 0, and enter EMIT_D at the next edge.
REQ-016 Legal arguments: 1<=N<=MAX_OPND and every digit of operands 0..N-1 <=9; digits at index >=N are ignored.
REQ-017 Illegal start SHALL pulse err for one cycle, emit no characters, and leave the FSM in IDLE.
REQ-018 EMIT_D: out=48+digit[i] (ASCII '0'..'9'), out_valid=1.
REQ-019 EMIT_O: out=43 if op_sel[i]=0, else 42; out_valid=1.
REQ-020 A character SHALL be accepted only in a cycle with out_valid=1 and out_ready=1.
REQ-021 While out_ready=0, out and out_valid SHALL hold stable, with no skip and no repeat.
REQ-022 On acceptance in EMIT_D: if i==N-1, go to DONE; otherwise go to EMIT_O.
REQ-023 On acceptance in EMIT_O: increment i and go to EMIT_D.
REQ-024 DONE SHALL last exactly one cycle with done=1 and out_valid=0, then return to IDLE.
REQ-025 start SHALL be ignored in EMIT_D, EMIT_O and DONE; it is not queued.
REQ-026 Latency: start sampled at edge k gives out_valid=1 in the cycle after edge k.
REQ-027 With out_ready held at 1, the block SHALL emit 2N-1 characters back-to-back and assert done in the cycle after the last acceptance.
REQ-028 For N=1, the block SHALL emit a single digit with no operator.
REQ-029 Outside EMIT_D and EMIT_O, out SHALL be 8'd0 and out_valid SHALL be 0.
REQ-030 All outputs SHALL be driven from registers; out_ready SHALL have no combinational path to any output.

Reset
REQ-031 clr_n=0 sampled at any edge SHALL force IDLE, i=0, out=0, out_valid=0, busy=0, done=0 and err=0, including in the middle of an expression.
REQ-032 An expression interrupted by reset SHALL NOT resume; a new start is required.
REQ-033 If clr_n=0 and start=1 are sampled at the same edge, reset SHALL win and the start SHALL be discarded.

Structure
REQ-034 A shared package SHALL hold the state enum, ASCII constants (ZERO=48, PLUS=43, STAR=42) and the MAX_OPND default.
REQ-035 One sub-module SHALL exist: expr_gen_chk, combinational legality check of num_opnd and opnd that produces the illegal flag.

Verification
REQ-036 The bench SHALL cover: N=3, opnd={3,2,1}, op_sel=2'b10, out_ready=1 -> out 49,43,50,42,51 on consecutive cycles, then done; when fed to the recognizer, its out=1 after the fifth character.
REQ-037 The bench SHALL cover: the same stimulus with out_ready=0 for 3 cycles while out=43 -> 43 held for 4 cycles, the sequence completes unchanged, done once.
REQ-038 The bench SHALL cover: N=2, digit0=10 -> err pulse one cycle, out_valid stays 0, FSM stays in IDLE.
REQ-039 The bench SHALL cover: clr_n=0 for one cycle after the second character -> out_valid=0 and busy=0 after that edge, no done; a new start restarts at operand 0.
REQ-040 The bench SHALL cover: N=1, digit=7 -> single character 55, done the cycle after acceptance; start pulsed during busy is ignored.
REQ-041 The bench SHALL cover: N=MAX_OPND, all op_sel=1 -> 2*MAX_OPND-1 characters alternating digit and 42, done once.
